// File: rtl/mio_bus_responder_if.sv
// CPU-side memory/IO handshake bundle: request strobe, direction, address,
// write data going in; completion pulse and read data coming back.
interface mio_bus_responder_if;
  logic        CPU_MIO;
  logic        mem_w;
  logic [31:0] addr;
  logic [31:0] Data_out;
  logic        MIO_ready;
  logic [31:0] Data_in;

  modport master (
    output CPU_MIO, mem_w, addr, Data_out,
    input  MIO_ready, Data_in
  );

  modport slave (
    input  CPU_MIO, mem_w, addr, Data_out,
    output MIO_ready, Data_in
  );
endinterface

// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder: decodes RAM / GPIO / counter regions, inserts wait
// states, then completes with a one-cycle MIO_ready. Optional MIO_BUS_ERR_EN adds bus_err.
module mio_bus_responder #(
  parameter int WAIT_CYCLES = 0,
  parameter int RAM_AW      = 10
) (
  input  logic              clk,
  input  logic              rst,
  mio_bus_responder_if.slave bus,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [31:0]       counter_val,
  output logic              counter_we,
  output logic [31:0]       bus_wdata,
  output logic [31:0]       gpio_out
`ifdef MIO_BUS_ERR_EN
  ,
  output logic              bus_err
`endif
);

  typedef enum logic [1:0] {IDLE, ACCESS, SETTLE, DONE} state_t;
  typedef enum logic [1:0] {REG_RAM, REG_GPIO, REG_CNT, REG_NONE} region_t;

  state_t              state_q, state_d;
  region_t             region_q, region_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [RAM_AW-1:0]   raddr_q, raddr_d;
  logic [31:0]         din_q, din_d;
  logic [31:0]         gpio_q, gpio_d;
  logic                mio_ready;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[27:RAM_AW+2], bus.addr[1:0]};

  function automatic region_t decode(input logic [3:0] nib);
    case (nib)
      4'h0:    decode = REG_RAM;
      4'hE:    decode = REG_GPIO;
      4'hF:    decode = REG_CNT;
      default: decode = REG_NONE;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      region_q <= REG_NONE;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      wdata_q  <= 32'd0;
      raddr_q  <= '0;
      din_q    <= 32'd0;
      gpio_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      region_q <= region_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      raddr_q  <= raddr_d;
      din_q    <= din_d;
      gpio_q   <= gpio_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    region_d = region_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    raddr_d  = raddr_q;
    din_d    = din_q;
    gpio_d   = gpio_q;
    case (state_q)
      IDLE: begin
        if (bus.CPU_MIO) begin
          we_d     = bus.mem_w;
          region_d = decode(bus.addr[31:28]);
          wdata_d  = bus.Data_out;
          raddr_d  = bus.addr[RAM_AW+1:2];
          cnt_d    = 4'(WAIT_CYCLES);
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) state_d = SETTLE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      SETTLE: begin
        state_d = DONE;
        // Reads capture the selected source; writes keep the previous Data_in.
        if (!we_q) begin
          case (region_q)
            REG_RAM:  din_d = ram_dout;
            REG_GPIO: din_d = gpio_q;
            REG_CNT:  din_d = counter_val;
            default:  din_d = 32'd0;
          endcase
        end else if (region_q == REG_GPIO) begin
          gpio_d = wdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mio_ready  = (state_q == DONE);
    ram_we     = mio_ready && we_q && (region_q == REG_RAM);
    counter_we = mio_ready && we_q && (region_q == REG_CNT);
`ifdef MIO_BUS_ERR_EN
    bus_err    = mio_ready && (region_q == REG_NONE);
`endif
  end

  assign bus.MIO_ready = mio_ready;
  assign bus.Data_in   = din_q;
  assign ram_addr      = raddr_q;
  assign bus_wdata     = wdata_q;
  assign gpio_out      = gpio_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Bench for mio_bus_responder: two instances (WAIT_CYCLES 0 and 3), directed
// cases followed by random transactions checked against a region-level model.
module tb_mio_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]       rst_a, cpu_mio, mem_w, ready, rwe, cwe;
  logic [1:0][31:0] addr, dout, cval, din, bwd, gpio;
  logic [1:0][9:0]  raddr;
`ifdef MIO_BUS_ERR_EN
  logic [1:0]       berr;
`endif

  int tests  = 0;
  int failed = 0;

  logic [31:0] ref_ram [int];
  logic [31:0] ref_din  [2];
  logic [31:0] ref_gpio [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mio_bus_responder_if bus ();
      logic [31:0] mem [1024] = '{default: 32'h0};
      logic [31:0] rd_q = 32'h0;

      assign bus.CPU_MIO  = cpu_mio[gi];
      assign bus.mem_w    = mem_w[gi];
      assign bus.addr     = addr[gi];
      assign bus.Data_out = dout[gi];
      assign ready[gi]    = bus.MIO_ready;
      assign din[gi]      = bus.Data_in;

      mio_bus_responder #(.WAIT_CYCLES(gi * 3), .RAM_AW(10)) u_dut (
        .clk        (clk),
        .rst        (rst_a[gi]),
        .bus        (bus.slave),
        .ram_addr   (raddr[gi]),
        .ram_we     (rwe[gi]),
        .ram_dout   (rd_q),
        .counter_val(cval[gi]),
        .counter_we (cwe[gi]),
        .bus_wdata  (bwd[gi]),
        .gpio_out   (gpio[gi])
`ifdef MIO_BUS_ERR_EN
        ,
        .bus_err    (berr[gi])
`endif
      );

      always @(posedge clk) begin
        if (rwe[gi]) mem[raddr[gi]] <= bwd[gi];
        rd_q <= mem[raddr[gi]];
      end
    end
  endgenerate

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int region_of(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'hE:    return 1;
      4'hF:    return 2;
      default: return 3;
    endcase
  endfunction

  task automatic drive(input int d, input bit w, input logic [31:0] a,
                       input logic [31:0] data, input logic [31:0] cv);
    mem_w[d]   = w;
    addr[d]    = a;
    dout[d]    = data;
    cval[d]    = cv;
    cpu_mio[d] = 1'b1;
  endtask

  // One CPU transaction. b2b: issue the request during the previous DONE cycle.
  // drop: release CPU_MIO right after capture. Other inputs are scrambled after capture.
  task automatic run_txn(input int d, input bit w, input logic [31:0] a,
                         input logic [31:0] data, input logic [31:0] cv,
                         input bit b2b, input bit drop);
    int          k;
    int          rg;
    int          key;
    logic [31:0] a_l;
    a_l = a;
    rg  = region_of(a_l);
    key = d * 1024 + int'(a_l[11:2]);
    if (b2b) drive(d, w, a, data, cv);
    else     cpu_mio[d] = 1'b0;
    @(posedge clk); @(negedge clk);
    check("ready_low_between", 32'(ready[d]), 32'd0);
    if (!b2b) drive(d, w, a, data, cv);
    k = 0;
    do begin
      @(posedge clk); @(negedge clk);
      k++;
      if (k == 1) begin
        if (drop) cpu_mio[d] = 1'b0;
        mem_w[d] = 1'($urandom);
        addr[d]  = $urandom;
        dout[d]  = $urandom;
      end
      if (!ready[d]) check("early_strobe", 32'({rwe[d], cwe[d]}), 32'd0);
    end while (!ready[d] && k < 40);
    check("latency", 32'(k), 32'(d * 3 + 3));
    if (!w) begin
      case (rg)
        0:       ref_din[d] = ref_ram.exists(key) ? ref_ram[key] : 32'h0;
        1:       ref_din[d] = ref_gpio[d];
        2:       ref_din[d] = cv;
        default: ref_din[d] = 32'h0;
      endcase
    end else if (rg == 0) begin
      ref_ram[key] = data;
    end else if (rg == 1) begin
      ref_gpio[d] = data;
    end
    check("Data_in", din[d], ref_din[d]);
    check("ram_we", 32'(rwe[d]), 32'(w && rg == 0));
    check("counter_we", 32'(cwe[d]), 32'(w && rg == 2));
    check("gpio_out", gpio[d], ref_gpio[d]);
    if (w && rg != 3) check("bus_wdata", bwd[d], data);
    if (rg == 0) check("ram_addr", 32'(raddr[d]), 32'(a_l[11:2]));
`ifdef MIO_BUS_ERR_EN
    check("bus_err", 32'(berr[d]), 32'(rg == 3));
`endif
    $display("[TB] dut%0d %s addr=%h wdata=%h Data_in=%h latency=%0d b2b=%0d drop=%0d",
             d, w ? "WR" : "RD", a, data, din[d], k, b2b, drop);
    cpu_mio[d] = 1'b0;
  endtask

  task automatic check_zero(input int d, input string tag);
    check({tag, "_ready"}, 32'(ready[d]), 32'd0);
    check({tag, "_we"}, 32'({rwe[d], cwe[d]}), 32'd0);
    check({tag, "_din"}, din[d], 32'd0);
    check({tag, "_gpio"}, gpio[d], 32'd0);
    check({tag, "_wdata"}, bwd[d], 32'd0);
    check({tag, "_raddr"}, 32'(raddr[d]), 32'd0);
  endtask

  initial begin
    int          d, prev, rg;
    bit          w, b2b, drop;
    logic [31:0] a, data;
    rst_a   = 2'b11;
    cpu_mio = 2'b00;
    mem_w   = 2'b00;
    addr    = '0;
    dout    = '0;
    cval    = '0;
    for (int i = 0; i < 2; i++) begin
      ref_din[i]  = 32'h0;
      ref_gpio[i] = 32'h0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_a = 2'b00;
    for (int i = 0; i < 2; i++) check_zero(i, "reset");

    // Directed cases from the plan
    run_txn(0, 1'b1, 32'h0000_0010, 32'h1234_5678, 32'h0, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'h0000_0010, 32'h0, 32'h0, 1'b0, 1'b0);
    run_txn(1, 1'b1, 32'hE000_0000, 32'h0000_00A5, 32'h0, 1'b0, 1'b0);
    run_txn(1, 1'b0, 32'hE000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'hF000_0000, 32'h0, 32'h0000_0BEE, 1'b0, 1'b0);
    run_txn(0, 1'b1, 32'hF000_0000, 32'h0000_0777, 32'h0000_0BEE, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'h5000_0000, 32'h0, 32'h0, 1'b0, 1'b0);
    run_txn(0, 1'b1, 32'h5000_0000, 32'h1111_2222, 32'h0, 1'b1, 1'b0);
    run_txn(0, 1'b1, 32'h0000_0020, 32'hABCD_0001, 32'h0, 1'b1, 1'b1);
    run_txn(0, 1'b0, 32'h0000_0020, 32'h0, 32'h0, 1'b1, 1'b0);

    // Reset during ACCESS of a RAM write on the WAIT_CYCLES=3 instance
    cpu_mio[1] = 1'b0;
    @(posedge clk); @(negedge clk);
    drive(1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0);
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_a[1]   = 1'b1;
    cpu_mio[1] = 1'b0;
    #1;
    check_zero(1, "midrst");
    ref_din[1]  = 32'h0;
    ref_gpio[1] = 32'h0;
    @(posedge clk); @(negedge clk);
    rst_a[1] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      check("post_rst_quiet", 32'({ready[1], rwe[1], cwe[1]}), 32'd0);
    end
    run_txn(1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 1'b0);
    run_txn(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 32'h0, 1'b0, 1'b0);
    run_txn(1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b1, 1'b0);

    // Random traffic against the region model
    prev = 1;
    for (int i = 0; i < 60; i++) begin
      d    = int'($urandom_range(1, 0));
      b2b  = (d == prev) && ($urandom_range(1, 0) == 1);
      drop = ($urandom_range(3, 0) == 0);
      w    = 1'($urandom);
      data = $urandom;
      rg   = int'($urandom_range(3, 0));
      a    = $urandom;
      case (rg)
        0:       a = {4'h0, a[27:6], 6'(a[1:0])};
        1:       a[31:28] = 4'hE;
        2:       a[31:28] = 4'hF;
        default: a[31:28] = 4'(1 + $urandom_range(12, 0));
      endcase
      run_txn(d, w, a, data, $urandom, b2b, drop);
      prev = d;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
